div: RTL and testbench

Multi-cycle radix-2 restoring divider serving the execute stage's DIV/DIVU instructions.
- Execute raises `start_i` with latched operands and stalls the pipeline until `ready_o`.
- It then forwards `result_o` (remainder to HI, quotient to LO) through its HI/LO write path.
- One quotient bit per cycle; 32-bit signed or unsigned operands; annullable mid-operation.

---
 rtl/div_pkg.sv | 38 +++
 rtl/div.sv | 154 +++++++++++++++
 tb/tb_div.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned DOUBLE_W = 2 * REG_W;
    localparam int unsigned WORK_W   = 2 * REG_W + 1;
    localparam int unsigned CNT_W    = 6;

    localparam logic RST_ENABLE           = 1'b1;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // HI/LO payload: remainder goes to HI, quotient to LO
    typedef struct packed {
        logic [REG_W-1:0] rem;
        logic [REG_W-1:0] quot;
    } div_result_t;

    // Two's-complement negate
    function automatic logic [REG_W-1:0] neg32(input logic [REG_W-1:0] x);
        return REG_W'(~x + REG_W'(1));
    endfunction

    // Magnitude of x when treated as signed; |0x80000000| stays 0x80000000
    function automatic logic [REG_W-1:0] abs32(input logic is_signed, input logic [REG_W-1:0] x);
        return (is_signed && x[REG_W-1]) ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
module div
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [REG_W-1:0]    opdata1_i,
    input  logic [REG_W-1:0]    opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [DOUBLE_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [WORK_W-1:0] work_q,    work_d;
    logic [REG_W-1:0]  divisor_q, divisor_d;
    logic              sign1_q,   sign1_d;
    logic              sign2_q,   sign2_d;
    logic              sdiv_q,    sdiv_d;
    div_result_t       result_q,  result_d;
    logic              ready_q,   ready_d;

    logic [REG_W:0]    diff_c;
    logic [REG_W-1:0]  quot_c;
    logic [REG_W-1:0]  rem_c;

    // Trial subtraction of the divisor from the partial remainder
    always_comb begin
        diff_c = work_q[WORK_W-1:REG_W] - {1'b0, divisor_q};
    end

    // Sign-corrected quotient and remainder from the finished working register
    always_comb begin
        quot_c = work_q[REG_W-1:0];
        rem_c  = work_q[WORK_W-1:REG_W+1];
        if (sdiv_q && (sign1_q != sign2_q)) begin
            quot_c = neg32(work_q[REG_W-1:0]);
        end
        if (sdiv_q && sign1_q) begin
            rem_c = neg32(work_q[WORK_W-1:REG_W+1]);
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        sdiv_d    = sdiv_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        sdiv_d    = signed_div_i;
                        sign1_d   = opdata1_i[REG_W-1];
                        sign2_d   = opdata2_i[REG_W-1];
                        divisor_d = abs32(signed_div_i, opdata2_i);
                        work_d    = {REG_W'(0), abs32(signed_div_i, opdata1_i), 1'b0};
                    end
                end
            end

            DIV_BY_ZERO: begin
                result_d = '0;
                if (annul_i) begin
                    state_d = DIV_FREE;
                    ready_d = DIV_RESULT_NOT_READY;
                end else begin
                    state_d = DIV_END;
                    ready_d = DIV_RESULT_READY;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else if (cnt_q != CNT_W'(REG_W)) begin
                    // Restore by not committing the difference when it went negative
                    if (diff_c[REG_W]) begin
                        work_d = {work_q[WORK_W-2:0], 1'b0};
                    end else begin
                        work_d = {diff_c[REG_W-1:0], work_q[REG_W-1:0], 1'b1};
                    end
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end else begin
                    state_d       = DIV_END;
                    cnt_d         = '0;
                    result_d.rem  = rem_c;
                    result_d.quot = quot_c;
                    ready_d       = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            sdiv_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            sdiv_q    <= sdiv_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: vector table, corner sequences, scoreboard.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    // Independent reference: native SV division, with the signed overflow case pinned
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = a;
            sb = b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sq = sa / sb;
            sr = sa % sb;
            return {32'(sr), 32'(sq)};
        end
        return {a % b, a / b};
    endfunction

    // One full transaction: start, wait for ready, compare, hold, release
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input int hold, input string name);
        int cycles;
        logic [63:0] want;
        @(negedge clk);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        exp_q.push_back(exp);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!ready && cycles < 200);
        want = exp_q.pop_front();
        if (!ready) begin
            check({name, " timeout"}, 64'(ready), 64'd1);
        end else begin
            check({name, " latency"}, 64'(cycles), 64'(lat));
            check({name, " result"}, result, want);
        end
        for (int i = 0; i < hold; i++) begin
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = ~signed_div;
            @(posedge clk);
            @(negedge clk);
            check({name, " hold"}, {result[62:0], ready}, {want[62:0], 1'b1});
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, " release"}, {result[62:0], ready}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        logic seen;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34, 0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 34, 0};
        vecs[2]  = '{1'b0, 32'd12345,      32'd0,          64'h0,                  2, 0};
        vecs[3]  = '{1'b1, 32'hFFFF_FFF0,  32'd0,          64'h0,                  2, 0};
        vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 34, 0};
        vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 34, 0};
        vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 34, 0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 34, 0};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,         64'h00000005_00000000, 34, 0};
        vecs[9]  = '{1'b0, 32'h8000_0000,  32'd2,          64'h00000000_40000000, 34, 0};
        vecs[10] = '{1'b1, 32'h8000_0000,  32'd2,          64'h00000000_C0000000, 34, 5};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 34, 0};

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
                    vecs[i].lat, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Start with annul high is not accepted
        @(negedge clk);
        opdata1 = 32'd9; opdata2 = 32'd3; start = 1'b1; annul = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("annul blocks start", 64'(seen), 64'd0);
        start = 1'b0; annul = 1'b0;

        // Annul at cnt=10, then a fresh division
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("annul pre ready", 64'(ready), 64'd0);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); @(negedge clk);
        annul = 1'b0;
        check("annul outputs", {result[62:0], ready}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34, 0, "post annul");

        // Reset at cnt=20 wins, then a fresh division
        @(negedge clk);
        signed_div = 1'b1; opdata1 = 32'h0000_FFFF; opdata2 = 32'd3; start = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; annul = 1'b1; start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("reset mid outputs", {result[62:0], ready}, 64'd0);
        rst = 1'b0; annul = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("reset no ready", 64'(seen), 64'd0);
        run_div(1'b1, 32'hFFFF_FC18, 32'd7, model(1'b1, 32'hFFFF_FC18, 32'd7), 34, 0, "post reset");

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = 32'($urandom_range(1, 100000));
            if ($urandom_range(0, 1) == 1) rb = 32'(~rb + 32'd1);
            if (!rs && i[0]) rb = $urandom | 32'd1;
            run_div(rs, ra, rb, model(rs, ra, rb), 34, 0, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
